lcd_timing_ctrl: RTL and testbench

- Parametrised next-generation LCD/RGB timing controller for the display path.
- Generates programmable HS/VS/DE timing with configurable sync polarity.
- Shadows timing config and updates it only at frame boundaries; supports start/stop via an enable state machine.
- Issues pixel-fetch requests FETCH_LAT cycles ahead of DE, aligns returned pixels to DE, and flags underflow.

---
 rtl/lcd_timing_pkg.sv | 54 +++++
 rtl/lcd_delay_line.sv | 26 ++
 rtl/lcd_timing_ctrl.sv | 253 +++++++++++++++++++++++++
 tb/tb_lcd_timing_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_timing_pkg.sv
// Shared types for the LCD timing controller: FSM states, timing config
// bundle and the config legality check.
package lcd_timing_pkg;

  // Widest counter the struct can hold; modules zero-extend CNT_W fields.
  localparam int TW = 16;
  // Totals are summed two bits wider so they never overflow.
  localparam int SW = TW + 2;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  typedef struct packed {
    logic [TW-1:0] h_sync;
    logic [TW-1:0] h_back;
    logic [TW-1:0] h_disp;
    logic [TW-1:0] h_front;
    logic [TW-1:0] v_sync;
    logic [TW-1:0] v_back;
    logic [TW-1:0] v_disp;
    logic [TW-1:0] v_front;
    logic          hs_pol;
    logic          vs_pol;
  } tcfg_t;

  function automatic logic [SW-1:0] tsum(
    input logic [TW-1:0] a,
    input logic [TW-1:0] b,
    input logic [TW-1:0] c,
    input logic [TW-1:0] d
  );
    return SW'(a) + SW'(b) + SW'(c) + SW'(d);
  endfunction

  // Non-zero sync/display and both totals fit a cw-bit counter.
  function automatic logic cfg_legal(
    input tcfg_t       c,
    input int unsigned cw
  );
    logic [SW-1:0] ht;
    logic [SW-1:0] vt;
    logic [SW-1:0] lim;
    ht  = tsum(c.h_sync, c.h_back, c.h_disp, c.h_front);
    vt  = tsum(c.v_sync, c.v_back, c.v_disp, c.v_front);
    lim = SW'(1) << cw;
    return (c.h_disp != '0) && (c.v_disp != '0) &&
           (c.h_sync != '0) && (c.v_sync != '0) &&
           (ht <= lim) && (vt <= lim);
  endfunction

endpackage

// File: rtl/lcd_delay_line.sv
// Fixed-depth shift register aligning sync/DE to fetched pixels.
// Ports: clk, rstn (async low), din -> dout after DEPTH cycles.
module lcd_delay_line #(
  parameter int W     = 4,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] sr [DEPTH];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
    end else begin
      sr[0] <= din;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end

  assign dout = sr[DEPTH-1];

endmodule

// File: rtl/lcd_timing_ctrl.sv
// LCD/RGB timing controller: HS/VS/DE generation, frame-aligned config
// shadowing, pixel prefetch FETCH_LAT ahead of DE and underflow flag.
// Ports: clk, rstn, enable, cfg_* timing/polarity, cfg_update,
//   pix_req/pix_hpos/pix_vpos out, pix_valid/pix_data in,
//   hs/vs/de/data/frame_start out, busy, underflow(+_clr), cfg_err.
// Optional: LCD_TIMING_CTRL_TESTPAT_EN adds testpat (colour bars).
module lcd_timing_ctrl
  import lcd_timing_pkg::*;
#(
  parameter int CNT_W     = 12,
  parameter int PIX_W     = 24,
  parameter int FETCH_LAT = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             enable,
  input  logic [CNT_W-1:0] cfg_h_sync,
  input  logic [CNT_W-1:0] cfg_h_back,
  input  logic [CNT_W-1:0] cfg_h_disp,
  input  logic [CNT_W-1:0] cfg_h_front,
  input  logic [CNT_W-1:0] cfg_v_sync,
  input  logic [CNT_W-1:0] cfg_v_back,
  input  logic [CNT_W-1:0] cfg_v_disp,
  input  logic [CNT_W-1:0] cfg_v_front,
  input  logic             cfg_hs_pol,
  input  logic             cfg_vs_pol,
  input  logic             cfg_update,
`ifdef LCD_TIMING_CTRL_TESTPAT_EN
  input  logic             testpat,
`endif
  output logic             pix_req,
  output logic [CNT_W-1:0] pix_hpos,
  output logic [CNT_W-1:0] pix_vpos,
  input  logic             pix_valid,
  input  logic [PIX_W-1:0] pix_data,
  output logic             hs,
  output logic             vs,
  output logic             de,
  output logic [PIX_W-1:0] data,
  output logic             frame_start,
  output logic             busy,
  output logic             underflow,
  input  logic             underflow_clr,
  output logic             cfg_err
);

  state_t           state_q, state_d;
  tcfg_t            live, sh;
  logic             live_ok;
  logic [CNT_W-1:0] h_q, v_q;
  logic             pend_q, err_q, uf_q;
  logic             run, start, at_h_last, at_end, upd;
  logic             tp;

  logic [SW-1:0] h_act, h_end, h_tot;
  logic [SW-1:0] v_act, v_end, v_tot;
  logic [SW-1:0] hx, vx;
  logic [CNT_W-1:0] h_last, v_last;
  logic [CNT_W-1:0] hpos, vpos;
  logic in_h, in_v, win;

`ifdef LCD_TIMING_CTRL_TESTPAT_EN
  assign tp = testpat;
`else
  assign tp = 1'b0;
`endif

  always_comb begin
    live         = '0;
    live.h_sync  = TW'(cfg_h_sync);
    live.h_back  = TW'(cfg_h_back);
    live.h_disp  = TW'(cfg_h_disp);
    live.h_front = TW'(cfg_h_front);
    live.v_sync  = TW'(cfg_v_sync);
    live.v_back  = TW'(cfg_v_back);
    live.v_disp  = TW'(cfg_v_disp);
    live.v_front = TW'(cfg_v_front);
    live.hs_pol  = cfg_hs_pol;
    live.vs_pol  = cfg_vs_pol;
  end

  assign live_ok = cfg_legal(live, CNT_W);

  assign h_act  = SW'(sh.h_sync) + SW'(sh.h_back);
  assign h_end  = h_act + SW'(sh.h_disp);
  assign h_tot  = tsum(sh.h_sync, sh.h_back,
                       sh.h_disp, sh.h_front);
  assign v_act  = SW'(sh.v_sync) + SW'(sh.v_back);
  assign v_end  = v_act + SW'(sh.v_disp);
  assign v_tot  = tsum(sh.v_sync, sh.v_back,
                       sh.v_disp, sh.v_front);
  // Totals never exceed 2^CNT_W, so the last count fits CNT_W bits.
  assign h_last = CNT_W'(h_tot - SW'(1));
  assign v_last = CNT_W'(v_tot - SW'(1));

  assign run       = (state_q != IDLE);
  assign start     = (state_q == IDLE) && enable && live_ok;
  assign at_h_last = (h_q == h_last);
  assign at_end    = run && at_h_last && (v_q == v_last);
  // A same-cycle cfg_update is honoured at this boundary.
  assign upd       = at_end && (pend_q || cfg_update);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (enable && live_ok) state_d = RUN;
      RUN:   if (!enable) state_d = at_end ? IDLE : DRAIN;
      DRAIN: begin
        if (enable)      state_d = RUN;
        else if (at_end) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      h_q     <= '0;
      v_q     <= '0;
    end else begin
      state_q <= state_d;
      if (!run) begin
        h_q <= '0;
        v_q <= '0;
      end else if (at_h_last) begin
        h_q <= '0;
        v_q <= (v_q == v_last) ? '0 : v_q + CNT_W'(1);
      end else begin
        h_q <= h_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sh     <= '0;
      pend_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      if (start || (upd && live_ok)) sh <= live;

      if (start || upd)    pend_q <= 1'b0;
      else if (cfg_update) pend_q <= 1'b1;

      if (start)
        err_q <= 1'b0;
      else if (!live_ok && (upd || (state_q == IDLE && enable)))
        err_q <= 1'b1;
    end
  end

  assign hx   = SW'(h_q);
  assign vx   = SW'(v_q);
  assign in_h = (hx >= h_act) && (hx < h_end);
  assign in_v = (vx >= v_act) && (vx < v_end);
  assign win  = run && in_h && in_v;
  assign hpos = CNT_W'(hx - h_act);
  assign vpos = CNT_W'(vx - v_act);

  assign pix_req  = win && !tp;
  assign pix_hpos = pix_req ? hpos : '0;
  assign pix_vpos = pix_req ? vpos : '0;

  logic fs_raw, hs_raw, vs_raw;
  logic fs_d, hs_d, vs_d, de_d;

  assign fs_raw = run && (h_q == '0) && (v_q == '0);
  assign hs_raw = run && (hx < SW'(sh.h_sync));
  assign vs_raw = run && (vx < SW'(sh.v_sync));

`ifdef LCD_TIMING_CTRL_TESTPAT_EN
  localparam int BW = 4 + CNT_W;
  logic [BW-1:0]    bdin, bdout;
  logic [CNT_W-1:0] hpos_d;
  assign bdin = {fs_raw, hs_raw, vs_raw, win, hpos};
  assign {fs_d, hs_d, vs_d, de_d, hpos_d} = bdout;
`else
  localparam int BW = 4;
  logic [BW-1:0] bdin, bdout;
  assign bdin = {fs_raw, hs_raw, vs_raw, win};
  assign {fs_d, hs_d, vs_d, de_d} = bdout;
`endif

  lcd_delay_line #(
    .W     (BW),
    .DEPTH (FETCH_LAT)
  ) u_dly (
    .clk  (clk),
    .rstn (rstn),
    .din  (bdin),
    .dout (bdout)
  );

  // Idle uses live polarity so sync is inactive straight out of reset.
  logic hs_pol, vs_pol;
  assign hs_pol = run ? sh.hs_pol : cfg_hs_pol;
  assign vs_pol = run ? sh.vs_pol : cfg_vs_pol;
  assign hs     = ~(hs_d ^ hs_pol);
  assign vs     = ~(vs_d ^ vs_pol);
  assign de     = de_d;
  assign frame_start = fs_d;

`ifdef LCD_TIMING_CTRL_TESTPAT_EN
  localparam int CW3 = PIX_W / 3;

  function automatic logic [PIX_W-1:0] bar_rgb(
    input logic [2:0] b
  );
    logic [2:0] m;
    case (b)
      3'd0:    m = 3'b111;
      3'd1:    m = 3'b110;
      3'd2:    m = 3'b011;
      3'd3:    m = 3'b010;
      3'd4:    m = 3'b101;
      3'd5:    m = 3'b100;
      3'd6:    m = 3'b001;
      default: m = 3'b000;
    endcase
    return PIX_W'({{CW3{m[2]}}, {CW3{m[1]}}, {CW3{m[0]}}});
  endfunction

  logic [SW-1:0]    bar_q;
  logic [PIX_W-1:0] tp_pix;
  assign bar_q  = SW'({hpos_d, 3'b000}) / SW'(sh.h_disp);
  assign tp_pix = bar_rgb(bar_q[2:0]);
`else
  logic [PIX_W-1:0] tp_pix;
  assign tp_pix = '0;
`endif

  always_comb begin
    data = '0;
    if (de_d) begin
      if (tp)             data = tp_pix;
      else if (pix_valid) data = pix_data;
    end
  end

  logic uf_set;
  assign uf_set = de_d && !pix_valid && !tp;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) uf_q <= 1'b0;
    else       uf_q <= uf_set | (uf_q & ~underflow_clr);
  end

  assign busy      = run;
  assign underflow = uf_q;
  assign cfg_err   = err_q;

endmodule

// File: tb/tb_lcd_timing_ctrl.sv
// Directed bench for lcd_timing_ctrl with a fixed-latency pixel
// responder; expected timings are hand-computed from the test config.
module tb_lcd_timing_ctrl;

  localparam int CW  = 12;
  localparam int PW  = 24;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rstn, enable, cfg_update, underflow_clr;
  logic [CW-1:0] cfg_h_sync, cfg_h_back, cfg_h_disp, cfg_h_front;
  logic [CW-1:0] cfg_v_sync, cfg_v_back, cfg_v_disp, cfg_v_front;
  logic cfg_hs_pol, cfg_vs_pol;
  logic pix_req, pix_valid;
  logic [CW-1:0] pix_hpos, pix_vpos;
  logic [PW-1:0] pix_data, data;
  logic hs, vs, de, frame_start, busy, underflow, cfg_err;

  always #5 clk = ~clk;

  lcd_timing_ctrl #(
    .CNT_W(CW), .PIX_W(PW), .FETCH_LAT(LAT)
  ) dut (
    .clk(clk), .rstn(rstn), .enable(enable),
    .cfg_h_sync(cfg_h_sync), .cfg_h_back(cfg_h_back),
    .cfg_h_disp(cfg_h_disp), .cfg_h_front(cfg_h_front),
    .cfg_v_sync(cfg_v_sync), .cfg_v_back(cfg_v_back),
    .cfg_v_disp(cfg_v_disp), .cfg_v_front(cfg_v_front),
    .cfg_hs_pol(cfg_hs_pol), .cfg_vs_pol(cfg_vs_pol),
    .cfg_update(cfg_update),
`ifdef LCD_TIMING_CTRL_TESTPAT_EN
    .testpat(1'b0),
`endif
    .pix_req(pix_req), .pix_hpos(pix_hpos), .pix_vpos(pix_vpos),
    .pix_valid(pix_valid), .pix_data(pix_data),
    .hs(hs), .vs(vs), .de(de), .data(data),
    .frame_start(frame_start), .busy(busy),
    .underflow(underflow), .underflow_clr(underflow_clr),
    .cfg_err(cfg_err)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic          q_req [LAT];
  logic [CW-1:0] q_h [LAT];
  logic [CW-1:0] q_v [LAT];
  int drops = 0;
  bit drop_armed = 0, clr_on_drop = 0, clr_req = 0, dropping = 0;

  // One pixel clock: respond to the request LAT cycles back, then
  // sample and check outputs on the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
    dropping = 0;
    underflow_clr = clr_req;
    clr_req = 0;
    if (q_req[LAT-1]) begin
      if (drop_armed && q_h[LAT-1] == CW'(3)) begin
        pix_valid = 1'b0;
        pix_data = 24'h5A5A5A;
        dropping = 1;
        drop_armed = 0;
        drops++;
        if (clr_on_drop) underflow_clr = 1'b1;
      end else begin
        pix_valid = 1'b1;
        pix_data = {q_h[LAT-1], q_v[LAT-1]};
      end
    end else begin
      pix_valid = 1'b1;
      pix_data = 24'hA5C3E1;
    end
    @(negedge clk);
    if (de) begin
      check("align", 32'(q_req[LAT-1]), 1);
      check("data", 32'(data),
            dropping ? 32'h0 : 32'({q_h[LAT-1], q_v[LAT-1]}));
    end else begin
      check("data_idle", 32'(data), 0);
    end
    if (!pix_req) check("pos_idle", 32'({pix_hpos, pix_vpos}), 0);
    for (int i = LAT - 1; i > 0; i--) begin
      q_req[i] = q_req[i-1];
      q_h[i] = q_h[i-1];
      q_v[i] = q_v[i-1];
    end
    q_req[0] = pix_req;
    q_h[0] = pix_hpos;
    q_v[0] = pix_vpos;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Measure one output frame from frame_start to the next one.
  task automatic measure(input int upd_at, input int off_at,
                         input int on_at, output int per,
                         output int lines, output int dl,
                         output int blo);
    int n, run;
    n = 0;
    while (!frame_start && n < 400) begin
      tick();
      n++;
    end
    check("fs_wait", 32'(frame_start), 1);
    per = 0; lines = 0; dl = 0; blo = 0; run = 0;
    do begin
      cfg_update = (per == upd_at);
      if (per == off_at) enable = 1'b0;
      if (per == on_at) enable = 1'b1;
      tick();
      per++;
      if (de) run++;
      else if (run > 0) begin
        lines++;
        if (dl == 0) dl = run;
        else if (dl != run) dl = -1;
        run = 0;
      end
      if (!busy) blo++;
    end while (!frame_start && per < 400);
    cfg_update = 1'b0;
  endtask

  task automatic chk_frame(input string tag, input int upd_at,
                           input int off_at, input int on_at,
                           input int e_per, input int e_dl);
    int per, lines, dl, blo;
    measure(upd_at, off_at, on_at, per, lines, dl, blo);
    check({tag, "_period"}, per, e_per);
    check({tag, "_lines"}, lines, 4);
    check({tag, "_delen"}, dl, e_dl);
    check({tag, "_busy"}, blo, 0);
  endtask

  initial begin
    int n, fs_n, req_n, de_n;
    logic [CW-1:0] hp, vp;
    for (int i = 0; i < LAT; i++) begin
      q_req[i] = 1'b0; q_h[i] = '0; q_v[i] = '0;
    end
    rstn = 1'b0; enable = 1'b0; cfg_update = 1'b0;
    underflow_clr = 1'b0; pix_valid = 1'b0; pix_data = '0;
    cfg_h_sync = 2; cfg_h_back = 3; cfg_h_disp = 8; cfg_h_front = 2;
    cfg_v_sync = 1; cfg_v_back = 1; cfg_v_disp = 4; cfg_v_front = 1;
    cfg_hs_pol = 1'b1; cfg_vs_pol = 1'b1;
    ticks(2);
    check("rst_busy", 32'(busy), 0);
    check("rst_de", 32'(de), 0);
    check("rst_data", 32'(data), 0);
    check("rst_fs", 32'(frame_start), 0);
    check("rst_req", 32'(pix_req), 0);
    check("rst_uf", 32'(underflow), 0);
    check("rst_err", 32'(cfg_err), 0);
    check("rst_hs", 32'(hs), 0);
    check("rst_vs", 32'(vs), 0);
    rstn = 1'b1;
    tick();

    // Start: H_TOTAL=15, V_TOTAL=7.
    enable = 1'b1;
    n = 0;
    while (!busy && n < 20) begin
      tick();
      n++;
    end
    check("start_busy", 32'(busy), 1);
    fs_n = -1; req_n = -1; de_n = -1; hp = '1; vp = '1;
    for (int k = 0; k < 60; k++) begin
      if (frame_start && fs_n < 0) fs_n = k;
      if (pix_req && req_n < 0) begin
        req_n = k; hp = pix_hpos; vp = pix_vpos;
      end
      if (de && de_n < 0) de_n = k;
      tick();
    end
    check("first_fs", fs_n, 2);
    check("first_req", req_n, 35);
    check("first_de", de_n, 37);
    check("first_hpos", 32'(hp), 0);
    check("first_vpos", 32'(vp), 0);
    chk_frame("base", -1, -1, -1, 105, 8);
    check("base_uf", 32'(underflow), 0);
    check("base_err", 32'(cfg_err), 0);

    // Underflow on a dropped response, then set-wins-over-clear.
    drop_armed = 1; clr_on_drop = 0;
    n = 0;
    while (drops < 1 && n < 300) begin
      tick();
      n++;
    end
    check("drop1_seen", drops, 1);
    ticks(3);
    check("uf_set", 32'(underflow), 1);
    ticks(10);
    check("uf_sticky", 32'(underflow), 1);
    clr_req = 1;
    ticks(2);
    check("uf_clr", 32'(underflow), 0);
    drop_armed = 1; clr_on_drop = 1;
    n = 0;
    while (drops < 2 && n < 300) begin
      tick();
      n++;
    end
    check("drop2_seen", drops, 2);
    clr_on_drop = 0;
    ticks(3);
    check("uf_set_wins", 32'(underflow), 1);
    clr_req = 1;
    ticks(2);
    check("uf_clr2", 32'(underflow), 0);

    // Mid-frame update to HD=6 lands at the next frame.
    cfg_h_disp = 6;
    chk_frame("upd_cur", 30, -1, -1, 105, 8);
    chk_frame("upd_new", -1, -1, -1, 91, 6);

    // Illegal update (VD=0) rejected, old timing kept.
    cfg_v_disp = 0;
    chk_frame("bad_cur", 30, -1, -1, 91, 6);
    check("upd_err", 32'(cfg_err), 1);
    cfg_v_disp = 4;
    chk_frame("keep", -1, -1, -1, 91, 6);

    // Stop mid-frame: frame completes, then idle.
    n = 0;
    while (!frame_start && n < 200) begin
      tick();
      n++;
    end
    check("stop_fs", 32'(frame_start), 1);
    ticks(20);
    enable = 1'b0;
    ticks(5);
    check("drain_busy", 32'(busy), 1);
    n = 25;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    check("drain_len", n, 89);
    ticks(4);
    check("stop_hs", 32'(hs), 0);
    check("stop_vs", 32'(vs), 0);
    check("stop_de", 32'(de), 0);
    cfg_hs_pol = 1'b0; cfg_vs_pol = 1'b0;
    tick();
    check("stop_hs_lo", 32'(hs), 1);
    check("stop_vs_lo", 32'(vs), 1);
    cfg_hs_pol = 1'b1; cfg_vs_pol = 1'b1;

    // Restart clears cfg_err; re-enable inside DRAIN keeps cadence.
    cfg_h_disp = 8;
    enable = 1'b1;
    ticks(3);
    check("restart_busy", 32'(busy), 1);
    check("restart_err", 32'(cfg_err), 0);
    chk_frame("redrain", -1, 20, 40, 105, 8);
    chk_frame("after", -1, -1, -1, 105, 8);

    // Illegal enable from IDLE.
    enable = 1'b0;
    n = 0;
    while (busy && n < 300) begin
      tick();
      n++;
    end
    check("stop2", 32'(busy), 0);
    cfg_h_disp = 0;
    enable = 1'b1;
    ticks(4);
    check("bad_busy", 32'(busy), 0);
    check("bad_err", 32'(cfg_err), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
